control_sequencer: RTL and testbench
====================================

# control_sequencer

Microcoded control unit for the 4-bit-address CPU. It is the initiator side of the program-counter control interface and drives the PC's count, output and load enables. It also drives the load and output strobes of MAR, RAM, IR, A, B, ALU and the output register through a fixed fetch/execute step sequence. It holds the carry/zero flag register used by conditional jumps, and it latches halt.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; clock clk.
- instr  in  8  IR contents; [7:4] opcode, [3:0] operand (operand reaches the bus via ir_oe, not through this block).
- carry_in  in  1  ALU carry-out of the current A±B result.
- zero_in  in  1  ALU result-is-zero.
- pc_ce, pc_oe, pc_ie  out  1 each  PC count enable, PC bus drive, PC load from bus.
- mar_ie  out  1  MAR load.
- ram_oe, ram_ie  out  1 each  RAM read to bus, RAM write from bus.
- ir_ie, ir_oe  out  1 each  IR load, IR operand to bus.
- a_ie, a_oe, b_ie  out  1 each  A load, A drive, B load.
- alu_oe, alu_sub  out  1 each  ALU result to bus, subtract select.
- out_ie  out  1  output register load.
- halted  out  1  CPU halted.
- step  out  3  current micro-step, 0..4.

## Operation
- State is:
  - step register (T0..T4);
  - flag_c and flag_z;
  - halt latch.
- Control outputs are a combinational decode of step, instr[7:4], the flags and halt. There is no other input-to-output path.
- Fetch, for every opcode:
  - T0: pc_oe, mar_ie.
  - T1: ram_oe, ir_ie, pc_ce.
- Execute (all strobes not listed are 0):
  - 0000 NOP: none.
  - 0001 LDA:
    - T2: ir_oe, mar_ie.
    - T3: ram_oe, a_ie.
  - 0010 ADD:
    - T2: ir_oe, mar_ie.
    - T3: ram_oe, b_ie.
    - T4: alu_oe, a_ie.
  - 0011 SUB: as ADD, plus alu_sub in T3 and T4.
  - 0100 STA:
    - T2: ir_oe, mar_ie.
    - T3: a_oe, ram_ie.
  - 0101 LDI: T2: ir_oe, a_ie.
  - 0110 JMP: T2: ir_oe, pc_ie.
  - 0111 JC: T2: ir_oe, and pc_ie only if flag_c=1.
  - 1000 JZ: T2: ir_oe, and pc_ie only if flag_z=1.
  - 1110 OUT: T2: a_oe, out_ie.
  - 1111 HLT: at T2, the halt latch sets on the closing edge.
  - Every other opcode executes as NOP.
- Flags:
  - flag_c ← carry_in and flag_z ← zero_in on the edge that ends T4 of ADD or SUB.
  - Flags are unchanged otherwise.
  - JC/JZ sample the flags registered before the current instruction.
- Invariants, required in every step:
  - At most one of pc_oe, ram_oe, ir_oe, a_oe, alu_oe is 1.
  - pc_ce and pc_ie are never both 1, because the PC gives count priority.
- Halt:
  - Once halted=1, step freezes at its current value and all strobes are 0.
  - Only reset clears halt.

## Timing
- While reset=1, all control outputs are 0 and halted=0. On the reset edge: step←0, flag_c←0, flag_z←0, halt←0.
- After reset deasserts, the first cycle is T0 with pc_oe=mar_ie=1.
- Step advances one per clock: T0→T1→T2→T3→T4→T0. The fixed instruction length is 5 cycles.
- instr must be stable from T2 through T4. IR loads on the T1→T2 edge.
- Reset asserted mid-instruction:
  - The instruction aborts on that edge and no partial flag update occurs.
  - A reset during ADD T4 does not latch flags.
- HLT:
  - halted rises in the cycle after T2.
  - step holds at 3.
- Reset dominates halt on the same edge.

## Configuration
- SEQ_EARLY_END_EN defined:
  - Step returns to T0 on the edge after the opcode's last active step.
  - Last active step is T3 for LDA and STA, T4 for ADD and SUB, and T2 for all others (NOP and undefined opcodes included).
  - Instruction lengths are 3, 4 or 5 cycles.
- SEQ_EARLY_END_EN not defined:
  - Every instruction runs the full T0..T4.
  - Unused steps assert no strobes.
- Flag, halt and strobe behaviour is identical in both builds.

## Test plan
- Reset, then instr=8'h00 (NOP) for 10 cycles:
  - step follows 0,1,2,3,4,0,…
  - pc_oe&mar_ie is 1 in T0 and pc_ce is 1 in T1.
  - With SEQ_EARLY_END_EN, step is 0,1,2,0,….
- ADD with carry_in=1, zero_in=0 in T4:
  - Strobes are T2 ir_oe+mar_ie, T3 ram_oe+b_ie, T4 alu_oe+a_ie with alu_sub=0.
  - flag_c=1 afterwards.
  - A following JC (8'h7A) asserts pc_ie in T2, and JZ (8'h8A) does not.
- SUB (8'h35) with zero_in=1:
  - alu_sub=1 in T3 and T4.
  - flag_z=1 afterwards.
  - JZ asserts pc_ie.
- HLT (8'hF0):
  - halted=1 from the cycle after T2.
  - step stays 3 for 20 cycles with all strobes 0.
  - Reset returns to step=0, halted=0.
- Reset pulse during ADD T4: no flag change, and the next cycle has step=0 with all strobes 0 during reset.
- Random opcode stream over 1000 instructions: the bus-exclusivity invariant holds, and pc_ce&pc_ie is never 1.

Source files
------------

// File: rtl/control_sequencer.sv
// Microcoded fetch/execute sequencer for the 4-bit-address CPU: step counter, C/Z flags, halt latch.
// Optional SEQ_EARLY_END_EN: each opcode returns to T0 after its last active step.
module control_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] instr,
  input  logic       carry_in,
  input  logic       zero_in,
  output logic       pc_ce,
  output logic       pc_oe,
  output logic       pc_ie,
  output logic       mar_ie,
  output logic       ram_oe,
  output logic       ram_ie,
  output logic       ir_ie,
  output logic       ir_oe,
  output logic       a_ie,
  output logic       a_oe,
  output logic       b_ie,
  output logic       alu_oe,
  output logic       alu_sub,
  output logic       out_ie,
  output logic       halted,
  output logic [2:0] step
);

  typedef enum logic [2:0] {T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4} step_t;

  localparam logic [3:0] OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_STA = 4'h4,
                         OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7, OP_JZ  = 4'h8,
                         OP_OUT = 4'hE, OP_HLT = 4'hF;

  step_t      cur_step;
  step_t      next_step;
  logic       flag_c;
  logic       flag_z;
  logic       halt;
  logic [3:0] opcode;
  logic       is_arith;
  logic       unused_operand;

  assign opcode         = instr[7:4];
  assign is_arith       = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign unused_operand = ^instr[3:0];

`ifdef SEQ_EARLY_END_EN
  step_t last_step;
  always_comb begin
    last_step = T2;
    if (opcode == OP_LDA || opcode == OP_STA) last_step = T3;
    else if (is_arith)                        last_step = T4;
  end
  assign next_step = (cur_step == last_step || cur_step == T4) ? T0 : step_t'(cur_step + 3'd1);
`else
  assign next_step = (cur_step == T4) ? T0 : step_t'(cur_step + 3'd1);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_step <= T0;
      flag_c   <= 1'b0;
      flag_z   <= 1'b0;
      halt     <= 1'b0;
    end else if (!halt) begin
      // HLT parks the step counter at T3 in both builds
      if (cur_step == T2 && opcode == OP_HLT) begin
        halt     <= 1'b1;
        cur_step <= T3;
      end else begin
        if (cur_step == T4 && is_arith) begin
          flag_c <= carry_in;
          flag_z <= zero_in;
        end
        cur_step <= next_step;
      end
    end
  end

  always_comb begin
    pc_ce = 1'b0; pc_oe = 1'b0; pc_ie = 1'b0; mar_ie = 1'b0;
    ram_oe = 1'b0; ram_ie = 1'b0; ir_ie = 1'b0; ir_oe = 1'b0;
    a_ie = 1'b0; a_oe = 1'b0; b_ie = 1'b0; alu_oe = 1'b0;
    alu_sub = 1'b0; out_ie = 1'b0;
    if (!reset && !halt) begin
      case (cur_step)
        T0: begin pc_oe = 1'b1; mar_ie = 1'b1; end
        T1: begin ram_oe = 1'b1; ir_ie = 1'b1; pc_ce = 1'b1; end
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin ir_oe = 1'b1; mar_ie = 1'b1; end
            OP_LDI: begin ir_oe = 1'b1; a_ie = 1'b1; end
            OP_JMP: begin ir_oe = 1'b1; pc_ie = 1'b1; end
            OP_JC:  begin ir_oe = 1'b1; pc_ie = flag_c; end
            OP_JZ:  begin ir_oe = 1'b1; pc_ie = flag_z; end
            OP_OUT: begin a_oe = 1'b1; out_ie = 1'b1; end
            default: ;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA: begin ram_oe = 1'b1; a_ie = 1'b1; end
            OP_ADD: begin ram_oe = 1'b1; b_ie = 1'b1; end
            OP_SUB: begin ram_oe = 1'b1; b_ie = 1'b1; alu_sub = 1'b1; end
            OP_STA: begin a_oe = 1'b1; ram_ie = 1'b1; end
            default: ;
          endcase
        end
        T4: begin
          if (is_arith) begin
            alu_oe  = 1'b1;
            a_ie    = 1'b1;
            alu_sub = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign halted = halt && !reset;
  assign step   = cur_step;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed plus random-opcode bench for control_sequencer; a cycle model fills a scoreboard queue.
module tb_control_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] instr;
  logic       carry_in, zero_in;
  logic       pc_ce, pc_oe, pc_ie, mar_ie, ram_oe, ram_ie, ir_ie, ir_oe;
  logic       a_ie, a_oe, b_ie, alu_oe, alu_sub, out_ie, halted;
  logic [2:0] step;

  control_sequencer dut (
    .clk(clk), .reset(reset), .instr(instr), .carry_in(carry_in), .zero_in(zero_in),
    .pc_ce(pc_ce), .pc_oe(pc_oe), .pc_ie(pc_ie), .mar_ie(mar_ie),
    .ram_oe(ram_oe), .ram_ie(ram_ie), .ir_ie(ir_ie), .ir_oe(ir_oe),
    .a_ie(a_ie), .a_oe(a_oe), .b_ie(b_ie), .alu_oe(alu_oe), .alu_sub(alu_sub),
    .out_ie(out_ie), .halted(halted), .step(step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [13:0] PC_CE = 14'h2000, PC_OE = 14'h1000, PC_IE = 14'h0800, MAR_IE = 14'h0400,
                          RAM_OE = 14'h0200, RAM_IE = 14'h0100, IR_IE = 14'h0080, IR_OE = 14'h0040,
                          A_IE = 14'h0020, A_OE = 14'h0010, B_IE = 14'h0008, ALU_OE = 14'h0004,
                          ALU_SUB = 14'h0002, OUT_IE = 14'h0001;

  int          checks = 0;
  int          errors = 0;
  logic [17:0] sb[$];
  logic [17:0] last_obs;
  logic [17:0] hist[0:4];
  int          m_step = 0;
  logic        m_c = 1'b0, m_z = 1'b0, m_halt = 1'b0;

  // Reference behaviour: {halted, step, strobes} expected for the current cycle.
  function automatic logic [17:0] model_word(input logic r, input logic [7:0] i);
    logic [13:0] s;
    s = '0;
    if (!r && !m_halt) begin
      case (m_step)
        0: s = PC_OE | MAR_IE;
        1: s = RAM_OE | IR_IE | PC_CE;
        2: case (i[7:4])
             4'h1, 4'h2, 4'h3, 4'h4: s = IR_OE | MAR_IE;
             4'h5: s = IR_OE | A_IE;
             4'h6: s = IR_OE | PC_IE;
             4'h7: s = IR_OE | (m_c ? PC_IE : 14'h0);
             4'h8: s = IR_OE | (m_z ? PC_IE : 14'h0);
             4'hE: s = A_OE | OUT_IE;
             default: s = '0;
           endcase
        3: case (i[7:4])
             4'h1: s = RAM_OE | A_IE;
             4'h2: s = RAM_OE | B_IE;
             4'h3: s = RAM_OE | B_IE | ALU_SUB;
             4'h4: s = A_OE | RAM_IE;
             default: s = '0;
           endcase
        4: case (i[7:4])
             4'h2: s = ALU_OE | A_IE;
             4'h3: s = ALU_OE | A_IE | ALU_SUB;
             default: s = '0;
           endcase
        default: s = '0;
      endcase
    end
    return {m_halt && !r, m_step[2:0], s};
  endfunction

  task automatic model_edge(input logic r, input logic [7:0] i, input logic c, input logic z);
    int last;
    if (r) begin
      m_step = 0; m_c = 1'b0; m_z = 1'b0; m_halt = 1'b0;
    end else if (!m_halt) begin
      if (m_step == 2 && i[7:4] == 4'hF) begin
        m_halt = 1'b1; m_step = 3;
      end else begin
        if (m_step == 4 && (i[7:4] == 4'h2 || i[7:4] == 4'h3)) begin
          m_c = c; m_z = z;
        end
`ifdef SEQ_EARLY_END_EN
        last = (i[7:4] == 4'h1 || i[7:4] == 4'h4) ? 3 : (i[7:4] == 4'h2 || i[7:4] == 4'h3) ? 4 : 2;
`else
        last = 4;
`endif
        m_step = (m_step == last) ? 0 : m_step + 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic [7:0] i, input logic c, input logic z);
    logic [17:0] e;
    reset = r; instr = i; carry_in = c; zero_in = z;
    sb.push_back(model_word(r, i));
    @(negedge clk);
    last_obs = {halted, step, pc_ce, pc_oe, pc_ie, mar_ie, ram_oe, ram_ie, ir_ie, ir_oe,
                a_ie, a_oe, b_ie, alu_oe, alu_sub, out_ie};
    e = sb.pop_front();
    chk("scoreboard", last_obs, e);
    chk("bus_exclusive", 18'($onehot0({pc_oe, ram_oe, ir_oe, a_oe, alu_oe})), 18'd1);
    chk("pc_ce_pc_ie", 18'(pc_ce & pc_ie), 18'd0);
    @(posedge clk);
    model_edge(r, i, c, z);
    #1;
  endtask

  task automatic run_instr(input logic [7:0] i, input logic c, input logic z);
    int s;
    for (int k = 0; k < 5; k++) hist[k] = '0;
    for (int k = 0; k < 5; k++) begin
      s = m_step;
      cycle(1'b0, i, c, z);
      hist[s] = last_obs;
      if (m_step == 0 || m_halt) break;
    end
  endtask

  int exp_steps[10];

  initial begin
    reset = 1'b1; instr = 8'h00; carry_in = 1'b0; zero_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cycle(1'b1, 8'h00, 1'b0, 1'b0);
    chk("reset_state", last_obs, 18'h0);

    // NOP stream: step sequence and fetch strobes
`ifdef SEQ_EARLY_END_EN
    exp_steps = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0};
`else
    exp_steps = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
`endif
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      chk($sformatf("nop_step%0d", k), 18'(last_obs[16:14]), 18'(exp_steps[k]));
      if (exp_steps[k] == 0) chk("nop_t0", 18'(last_obs[13:0]), 18'(PC_OE | MAR_IE));
      if (exp_steps[k] == 1) chk("nop_t1", 18'(last_obs[13:0]), 18'(RAM_OE | IR_IE | PC_CE));
    end
    while (m_step != 0) cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // ADD with carry, then JC taken / JZ not taken
    run_instr(8'h2A, 1'b1, 1'b0);
    chk("add_t2", 18'(hist[2][13:0]), 18'(IR_OE | MAR_IE));
    chk("add_t3", 18'(hist[3][13:0]), 18'(RAM_OE | B_IE));
    chk("add_t4", 18'(hist[4][13:0]), 18'(ALU_OE | A_IE));
    run_instr(8'h7A, 1'b0, 1'b0);
    chk("jc_taken", 18'(hist[2][13:0]), 18'(IR_OE | PC_IE));
    run_instr(8'h8A, 1'b0, 1'b0);
    chk("jz_not_taken", 18'(hist[2][13:0]), 18'(IR_OE));

    // SUB with zero result
    run_instr(8'h35, 1'b0, 1'b1);
    chk("sub_t3", 18'(hist[3][13:0]), 18'(RAM_OE | B_IE | ALU_SUB));
    chk("sub_t4", 18'(hist[4][13:0]), 18'(ALU_OE | A_IE | ALU_SUB));
    run_instr(8'h8A, 1'b0, 1'b0);
    chk("jz_taken", 18'(hist[2][13:0]), 18'(IR_OE | PC_IE));
    run_instr(8'h7A, 1'b0, 1'b0);
    chk("jc_cleared", 18'(hist[2][13:0]), 18'(IR_OE));

    // Reset landing on ADD T4 must not update flags
    for (int k = 0; k < 4; k++) cycle(1'b0, 8'h2A, 1'b1, 1'b0);
    cycle(1'b1, 8'h2A, 1'b1, 1'b0);
    chk("reset_t4_strobes", 18'(last_obs[13:0]), 18'h0);
    cycle(1'b1, 8'h2A, 1'b1, 1'b0);
    chk("reset_after", last_obs, 18'h0);
    run_instr(8'h7A, 1'b0, 1'b0);
    chk("jc_after_reset", 18'(hist[2][13:0]), 18'(IR_OE));
    run_instr(8'h8A, 1'b0, 1'b0);
    chk("jz_after_reset", 18'(hist[2][13:0]), 18'(IR_OE));

    // HLT freezes at step 3 until reset
    run_instr(8'hF0, 1'b0, 1'b0);
    chk("hlt_t2", hist[2], {1'b0, 3'd2, 14'h0});
    for (int k = 0; k < 20; k++) cycle(1'b0, 8'hF0, 1'b0, 1'b0);
    chk("halt_hold", last_obs, {1'b1, 3'd3, 14'h0});
    cycle(1'b1, 8'hF0, 1'b0, 1'b0);
    chk("halt_reset", 18'(last_obs[17]), 18'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("post_halt_t0", last_obs, {1'b0, 3'd0, PC_OE | MAR_IE});
    while (m_step != 0) cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Random opcode stream (HLT excluded so the run keeps moving)
    for (int n = 0; n < 1000; n++) begin
      logic [7:0] r_i;
      r_i = 8'($urandom_range(0, 255));
      if (r_i[7:4] == 4'hF) r_i[7:4] = 4'hE;
      run_instr(r_i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
